// File: rtl/computational_unit_param.sv
// computational_unit_param
// Parametrised computational unit for the course microprocessor datapath.
// It holds NUM_XY x and NUM_XY y operand registers, the r/m/i/o registers,
// a data-bus source mux and an ALU. The ALU has single-cycle arithmetic,
// logic and shift ops, plus an iterative shift-add multiplier with a
// busy/done handshake.
//
// Ports:
//   clk, reset_n             rising-edge clock, asynchronous active-low reset
//   i_pins, dm, pm_data      external pins, data-memory read data, immediate
//   src_sel, src_idx         data-bus source select and x/y index
//   x_en, y_en               one-hot-or-zero x/y register write enables
//   m_en, i_en, o_en, i_sel  m/i/o write enables; i_sel=1 loads i with i+m
//   x_sel, y_sel             ALU operand selects
//   alu_op, alu_go           ALU function and operation request
//   data_bus                 combinational bus value
//   x_flat, y_flat           x/y register contents, x[k] at [k*DATA_W +: DATA_W]
//   r, m, i, o_reg           registers
//   flag_z, flag_c, flag_n   result flags
//   busy, done               multiplier running / one-cycle result pulse
module computational_unit_param #(
  parameter int DATA_W = 4,
  parameter int NUM_XY = 2,
  parameter int IDX_W  = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [DATA_W-1:0]        i_pins,
  input  logic [DATA_W-1:0]        dm,
  input  logic [DATA_W-1:0]        pm_data,
  input  logic [3:0]               src_sel,
  input  logic [IDX_W-1:0]         src_idx,
  input  logic [NUM_XY-1:0]        x_en,
  input  logic [NUM_XY-1:0]        y_en,
  input  logic                     m_en,
  input  logic                     i_en,
  input  logic                     o_en,
  input  logic                     i_sel,
  input  logic [IDX_W-1:0]         x_sel,
  input  logic [IDX_W-1:0]         y_sel,
  input  logic [3:0]               alu_op,
  input  logic                     alu_go,
  output logic [DATA_W-1:0]        data_bus,
  output logic [NUM_XY*DATA_W-1:0] x_flat,
  output logic [NUM_XY*DATA_W-1:0] y_flat,
  output logic [DATA_W-1:0]        r,
  output logic [DATA_W-1:0]        m,
  output logic [DATA_W-1:0]        i,
  output logic [DATA_W-1:0]        o_reg,
  output logic                     flag_z,
  output logic                     flag_c,
  output logic                     flag_n,
  output logic                     busy,
  output logic                     done
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  localparam logic [3:0] OP_NEG   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_MULHI = 4'd3;
  localparam logic [3:0] OP_MULLO = 4'd4;
  localparam logic [3:0] OP_XOR   = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_NOT   = 4'd7;
  localparam logic [3:0] OP_OR    = 4'd8;
  localparam logic [3:0] OP_SHL   = 4'd9;
  localparam logic [3:0] OP_SHR   = 4'd10;

  typedef enum logic {ST_IDLE, ST_RUN} state_t;

  state_t              state_reg, state_next;
  logic [DATA_W-1:0]   x_op, y_op;
  logic [DATA_W:0]     sum_ext, diff_ext;
  logic [DATA_W-1:0]   alu_res;
  logic                alu_c, op_single, op_mul;
  logic                single_fire, mul_accept, mul_last;

  // Multiplier: acc_reg holds the running upper half, mplier_reg shifts the
  // multiplier out at the bottom while product bits shift in at the top.
  logic [DATA_W-1:0]   mcand_reg, mplier_reg, acc_reg;
  logic                mul_hi_reg;
  logic [CNT_W-1:0]    count_reg;
  logic [DATA_W:0]     step_sum;
  logic [DATA_W-1:0]   acc_step, mplier_step, mul_res;

  // x/y operand register banks
  genvar gi;
  generate
    for (gi = 0; gi < NUM_XY; gi++) begin : g_xy
      logic [DATA_W-1:0] x_reg, y_reg;
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          x_reg <= '0;
          y_reg <= '0;
        end else begin
          if (x_en[gi]) x_reg <= data_bus;
          if (y_en[gi]) y_reg <= data_bus;
        end
      end
      assign x_flat[gi*DATA_W +: DATA_W] = x_reg;
      assign y_flat[gi*DATA_W +: DATA_W] = y_reg;
    end
  endgenerate

  assign x_op = x_flat[int'(x_sel)*DATA_W +: DATA_W];
  assign y_op = y_flat[int'(y_sel)*DATA_W +: DATA_W];

  always_comb begin
    data_bus = '0;
    case (src_sel)
      4'd0:    data_bus = x_flat[int'(src_idx)*DATA_W +: DATA_W];
      4'd1:    data_bus = y_flat[int'(src_idx)*DATA_W +: DATA_W];
      4'd2:    data_bus = r;
      4'd3:    data_bus = m;
      4'd4:    data_bus = i;
      4'd5:    data_bus = dm;
      4'd6:    data_bus = pm_data;
      4'd7:    data_bus = i_pins;
      default: data_bus = '0;
    endcase
  end

  // m/i/o registers; i+m uses the pre-edge m even when m is also written
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m     <= '0;
      i     <= '0;
      o_reg <= '0;
    end else begin
      if (m_en) m <= data_bus;
      if (i_en) i <= i_sel ? (i + m) : data_bus;
      if (o_en) o_reg <= data_bus;
    end
  end

  // Single-cycle ALU
  assign sum_ext  = {1'b0, x_op} + {1'b0, y_op};
  assign diff_ext = {1'b0, x_op} - {1'b0, y_op};

  always_comb begin
    alu_res   = '0;
    alu_c     = 1'b0;
    op_single = 1'b1;
    op_mul    = 1'b0;
    case (alu_op)
      OP_NEG:   begin alu_res = -x_op; alu_c = |x_op; end
      OP_SUB:   begin alu_res = diff_ext[DATA_W-1:0]; alu_c = diff_ext[DATA_W]; end
      OP_ADD:   begin alu_res = sum_ext[DATA_W-1:0]; alu_c = sum_ext[DATA_W]; end
      OP_MULHI,
      OP_MULLO: begin op_single = 1'b0; op_mul = 1'b1; end
      OP_XOR:   alu_res = x_op ^ y_op;
      OP_AND:   alu_res = x_op & y_op;
      OP_NOT:   alu_res = ~x_op;
      OP_OR:    alu_res = x_op | y_op;
      OP_SHL:   begin alu_res = {x_op[DATA_W-2:0], 1'b0}; alu_c = x_op[DATA_W-1]; end
      OP_SHR:   begin alu_res = {1'b0, x_op[DATA_W-1:1]}; alu_c = x_op[0]; end
      default:  op_single = 1'b0;
    endcase
  end

  // One shift-add step
  assign step_sum    = {1'b0, acc_reg} + (mplier_reg[0] ? {1'b0, mcand_reg} : '0);
  assign acc_step    = step_sum[DATA_W:1];
  assign mplier_step = {step_sum[0], mplier_reg[DATA_W-1:1]};
  assign mul_res     = mul_hi_reg ? acc_step : mplier_step;

  // FSM: state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_reg <= ST_IDLE;
    else          state_reg <= state_next;
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (mul_accept) state_next = ST_RUN;
      ST_RUN:  if (mul_last)   state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM: outputs. Requests are judged against the registered busy, so a
  // request during the final RUN cycle is dropped.
  always_comb begin
    busy        = (state_reg == ST_RUN);
    mul_accept  = (state_reg == ST_IDLE) && alu_go && op_mul;
    mul_last    = (state_reg == ST_RUN) && (count_reg == CNT_W'(1));
    single_fire = alu_go && !busy && op_single;
  end

  // Multiplier datapath, r and flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcand_reg  <= '0;
      mplier_reg <= '0;
      acc_reg    <= '0;
      mul_hi_reg <= 1'b0;
      count_reg  <= '0;
      done       <= 1'b0;
      r          <= '0;
      flag_z     <= 1'b1;
      flag_c     <= 1'b0;
      flag_n     <= 1'b0;
    end else begin
      done <= mul_last;
      if (mul_accept) begin
        mcand_reg  <= x_op;
        mplier_reg <= y_op;
        acc_reg    <= '0;
        mul_hi_reg <= (alu_op == OP_MULHI);
        count_reg  <= CNT_W'(DATA_W);
      end else if (busy) begin
        acc_reg    <= acc_step;
        mplier_reg <= mplier_step;
        count_reg  <= count_reg - 1'b1;
      end
      if (single_fire) begin
        r      <= alu_res;
        flag_z <= (alu_res == '0);
        flag_n <= alu_res[DATA_W-1];
        flag_c <= alu_c;
      end else if (mul_last) begin
        r      <= mul_res;
        flag_z <= (mul_res == '0);
        flag_n <= mul_res[DATA_W-1];
        flag_c <= |acc_step;
      end
    end
  end

endmodule

// File: tb/tb_computational_unit_param.sv
// Self-checking bench for computational_unit_param: directed cases plus a
// randomized phase, compared against a behavioural model through a queue of
// expected ALU results popped by an independent monitor.
module tb_computational_unit_param;

  localparam int W    = 4;
  localparam int N    = 2;
  localparam int IW   = 1;
  localparam int MASK = (1 << W) - 1;

  logic            clk, reset_n;
  logic [W-1:0]    i_pins, dm, pm_data;
  logic [3:0]      src_sel;
  logic [IW-1:0]   src_idx;
  logic [N-1:0]    x_en, y_en;
  logic            m_en, i_en, o_en, i_sel;
  logic [IW-1:0]   x_sel, y_sel;
  logic [3:0]      alu_op;
  logic            alu_go;
  logic [W-1:0]    data_bus;
  logic [N*W-1:0]  x_flat, y_flat;
  logic [W-1:0]    r, m, i, o_reg;
  logic            flag_z, flag_c, flag_n, busy, done;

  computational_unit_param #(.DATA_W(W), .NUM_XY(N), .IDX_W(IW)) dut (
    .clk(clk), .reset_n(reset_n), .i_pins(i_pins), .dm(dm), .pm_data(pm_data),
    .src_sel(src_sel), .src_idx(src_idx), .x_en(x_en), .y_en(y_en),
    .m_en(m_en), .i_en(i_en), .o_en(o_en), .i_sel(i_sel),
    .x_sel(x_sel), .y_sel(y_sel), .alu_op(alu_op), .alu_go(alu_go),
    .data_bus(data_bus), .x_flat(x_flat), .y_flat(y_flat),
    .r(r), .m(m), .i(i), .o_reg(o_reg),
    .flag_z(flag_z), .flag_c(flag_c), .flag_n(flag_n), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int due;
    int res;
    int z;
    int c;
    int n;
    bit is_mul;
  } exp_t;

  exp_t q[$];
  int   mx[N], my[N];
  int   mr, mm, mi, mo, mz, mc, mn;
  int   cyc = 0;
  int   busy_end = 0;        // first cycle at which the model is no longer busy
  int   pend_due = -1;
  int   pend_r, pend_c;
  bit   started = 0;

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin mx[k] = 0; my[k] = 0; end
    mr = 0; mm = 0; mi = 0; mo = 0; mz = 1; mc = 0; mn = 0;
    busy_end = 0; pend_due = -1;
    q.delete();
  endtask

  task automatic set_result(input int res, input int cf);
    mr = res; mc = cf; mz = (res == 0); mn = (res >> (W - 1)) & 1;
  endtask

  function automatic int model_bus();
    case (src_sel)
      4'd0: return mx[src_idx];
      4'd1: return my[src_idx];
      4'd2: return mr;
      4'd3: return mm;
      4'd4: return mi;
      4'd5: return int'(dm);
      4'd6: return int'(pm_data);
      4'd7: return int'(i_pins);
      default: return 0;
    endcase
  endfunction

  function automatic int flat_x();
    int v = 0;
    for (int k = 0; k < N; k++) v |= mx[k] << (k * W);
    return v;
  endfunction

  function automatic int flat_y();
    int v = 0;
    for (int k = 0; k < N; k++) v |= my[k] << (k * W);
    return v;
  endfunction

  // Advance one clock: evaluate the model on the currently driven inputs and
  // pre-edge state, then commit it at the edge.
  task automatic tick();
    int bus, xo, yo, res, cf, prod, nm, ni, no;
    int nx[N], ny[N];
    bit do_single, do_mul, live;
    exp_t e;
    do_single = 0; do_mul = 0; res = 0; cf = 0; prod = 0;
    live = reset_n;
    nx = mx; ny = my; nm = mm; ni = mi; no = mo;
    if (live) begin
      bus = model_bus();
      for (int k = 0; k < N; k++) begin
        if (x_en[k]) nx[k] = bus;
        if (y_en[k]) ny[k] = bus;
      end
      if (m_en) nm = bus;
      if (i_en) ni = i_sel ? ((mi + mm) & MASK) : bus;
      if (o_en) no = bus;
      if (alu_go && !(cyc < busy_end)) begin
        xo = mx[x_sel]; yo = my[y_sel];
        do_single = 1;
        case (alu_op)
          4'd0: begin res = (-xo) & MASK; cf = (xo != 0); end
          4'd1: begin res = (xo - yo) & MASK; cf = (xo < yo); end
          4'd2: begin res = (xo + yo) & MASK; cf = ((xo + yo) > MASK); end
          4'd3, 4'd4: begin
            do_single = 0; do_mul = 1;
            prod = xo * yo;
            res  = (alu_op == 4'd3) ? (prod >> W) : (prod & MASK);
            cf   = ((prod >> W) != 0);
          end
          4'd5: res = xo ^ yo;
          4'd6: res = xo & yo;
          4'd7: res = (~xo) & MASK;
          4'd8: res = xo | yo;
          4'd9: begin res = (xo * 2) & MASK; cf = (xo >= (1 << (W - 1))); end
          4'd10: begin res = xo / 2; cf = xo % 2; end
          default: do_single = 0;
        endcase
      end
    end
    @(posedge clk);
    cyc++;
    if (live) begin
      mx = nx; my = ny; mm = nm; mi = ni; mo = no;
      if (do_single) begin
        set_result(res, cf);
        e.due = cyc; e.res = res; e.z = mz; e.c = mc; e.n = mn; e.is_mul = 0;
        q.push_back(e);
      end
      if (do_mul) begin
        busy_end = cyc + W; pend_due = cyc + W; pend_r = res; pend_c = cf;
        e.due = cyc + W; e.res = res; e.z = (res == 0); e.c = cf;
        e.n = (res >> (W - 1)) & 1; e.is_mul = 1;
        q.push_back(e);
      end
      if (cyc == pend_due) begin
        set_result(pend_r, pend_c);
        pend_due = -1;
      end
    end
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    exp_t e;
    bit mul_now;
    mul_now = 0;
    if (started && reset_n) begin
      while (q.size() > 0 && q[0].due <= cyc) begin
        e = q.pop_front();
        chk("result_on_time", e.due, cyc);
        chk("sb_r", int'(r), e.res);
        chk("sb_z", int'(flag_z), e.z);
        chk("sb_c", int'(flag_c), e.c);
        chk("sb_n", int'(flag_n), e.n);
        if (e.is_mul) begin
          mul_now = 1;
          chk("sb_done", int'(done), 1);
        end
        $display("txn cyc=%0d mul=%0d r=%0d z=%0d c=%0d n=%0d", cyc, e.is_mul,
                 r, flag_z, flag_c, flag_n);
      end
      if (!mul_now) chk("done_idle", int'(done), 0);
      chk("busy", int'(busy), int'(cyc < busy_end));
      chk("r_hold", int'(r), mr);
      chk("flags", {29'd0, flag_z, flag_c, flag_n}, (mz << 2) | (mc << 1) | mn);
      chk("x_regs", int'(x_flat), flat_x());
      chk("y_regs", int'(y_flat), flat_y());
      chk("m_reg", int'(m), mm);
      chk("i_reg", int'(i), mi);
      chk("o_reg", int'(o_reg), mo);
      chk("data_bus", int'(data_bus), model_bus());
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    src_sel = 0; src_idx = 0; x_en = 0; y_en = 0; m_en = 0; i_en = 0; o_en = 0;
    i_sel = 0; x_sel = 0; y_sel = 0; alu_op = 0; alu_go = 0;
    pm_data = 0; dm = 0; i_pins = 0;
  endtask

  // which: 0 x, 1 y, 2 m, 3 i, 4 o
  task automatic load(input int which, input int k, input int val);
    idle();
    src_sel = 4'd6; pm_data = W'(val);
    case (which)
      0: x_en[k] = 1'b1;
      1: y_en[k] = 1'b1;
      2: m_en = 1'b1;
      3: i_en = 1'b1;
      default: o_en = 1'b1;
    endcase
    tick();
    idle();
  endtask

  task automatic op(input int opc, input int xs, input int ys);
    idle();
    alu_op = 4'(opc); x_sel = IW'(xs); y_sel = IW'(ys); alu_go = 1'b1;
    tick();
    idle();
  endtask

  task automatic mul_run(input int opc, input int exp_r, input int exp_c);
    int bcnt, dcnt;
    op(opc, 0, 0);
    bcnt = int'(busy); dcnt = 0;
    repeat (W + 2) begin
      tick();
      bcnt += int'(busy);
      dcnt += int'(done);
    end
    chk("mul_busy_cycles", bcnt, W);
    chk("mul_done_pulses", dcnt, 1);
    chk("mul_r", int'(r), exp_r);
    chk("mul_c", int'(flag_c), exp_c);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int guard;
    int rr;
    reset_n = 1'b0;
    idle();
    model_reset();
    tick();
    tick();
    chk("reset_r", int'(r), 0);
    chk("reset_z", int'(flag_z), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_x", int'(x_flat), 0);
    reset_n = 1'b1;
    started = 1;

    // ADD / SUB flag cases
    load(0, 0, 9); load(1, 0, 9);
    op(2, 0, 0);
    chk("add_r", int'(r), 2); chk("add_c", int'(flag_c), 1);
    chk("add_z", int'(flag_z), 0); chk("add_n", int'(flag_n), 0);
    load(0, 0, 3); load(1, 0, 5);
    op(1, 0, 0);
    chk("sub_r", int'(r), 14); chk("sub_c", int'(flag_c), 1); chk("sub_n", int'(flag_n), 1);
    load(1, 0, 3);
    op(1, 0, 0);
    chk("sub0_r", int'(r), 0); chk("sub0_z", int'(flag_z), 1); chk("sub0_c", int'(flag_c), 0);

    // Multiplier
    load(0, 0, 15); load(1, 0, 15);
    mul_run(3, 14, 1);
    mul_run(4, 1, 1);
    load(0, 0, 3); load(1, 0, 2);
    mul_run(4, 6, 0);
    chk("mul6_z", int'(flag_z), 0);

    // Operand latch, ignored request while busy, request in the done cycle
    load(0, 0, 15); load(1, 0, 15);
    op(3, 0, 0);
    tick();
    load(0, 0, 0);
    op(2, 0, 0);
    guard = 0;
    while (cyc < busy_end && guard < 20) begin tick(); guard++; end
    chk("latch_done", int'(done), 1);
    chk("latch_r", int'(r), 14);
    op(2, 0, 0);
    chk("done_cycle_add_r", int'(r), 15);
    chk("done_cycle_add_c", int'(flag_c), 0);

    // Reset in the middle of a multiply
    load(0, 0, 5); load(1, 0, 3);
    op(4, 0, 0);
    tick();
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_r", int'(r), 0);
    chk("midrst_z", int'(flag_z), 1);
    tick();
    reset_n = 1'b1;
    repeat (W + 2) tick();
    load(0, 0, 5); load(1, 0, 3);
    op(4, 0, 0);
    repeat (W) tick();
    chk("postrst_mul_r", int'(r), 15);
    chk("postrst_mul_c", int'(flag_c), 0);
    chk("postrst_mul_n", int'(flag_n), 1);

    // i <= i+m with old m; unused source yields 0
    load(3, 0, 14); load(2, 0, 3);
    idle();
    src_sel = 4'd6; pm_data = 4'd7; i_sel = 1; i_en = 1; m_en = 1;
    tick();
    idle();
    chk("i_plus_m", int'(i), 1);
    chk("m_new", int'(m), 7);
    src_sel = 4'd12;
    #1;
    chk("bus_unused_src", int'(data_bus), 0);
    idle();

    // Asynchronous reset between edges
    load(0, 1, 5); load(4, 0, 9);
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_x", int'(x_flat), 0);
    chk("async_o", int'(o_reg), 0);
    chk("async_z", int'(flag_z), 1);
    chk("async_busy", int'(busy), 0);
    #2;
    reset_n = 1'b1;
    tick();
    chk("async_hold_x", int'(x_flat), 0);
    chk("async_hold_o", int'(o_reg), 0);

    // Randomized traffic
    for (int t = 0; t < 400; t++) begin
      src_sel = 4'($urandom_range(0, 15));
      src_idx = IW'($urandom_range(0, N - 1));
      rr = $urandom_range(0, N); x_en = (rr == N) ? '0 : N'(1 << rr);
      rr = $urandom_range(0, N); y_en = (rr == N) ? '0 : N'(1 << rr);
      m_en = 1'($urandom_range(0, 1)); i_en = 1'($urandom_range(0, 1));
      o_en = 1'($urandom_range(0, 1)); i_sel = 1'($urandom_range(0, 1));
      x_sel = IW'($urandom_range(0, N - 1)); y_sel = IW'($urandom_range(0, N - 1));
      alu_op = 4'($urandom_range(0, 15)); alu_go = 1'($urandom_range(0, 1));
      pm_data = W'($urandom); dm = W'($urandom); i_pins = W'($urandom);
      tick();
    end
    idle();
    repeat (W + 2) tick();
    chk("queue_drained", q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
